// File: rtl/palette_lut.sv
// Palette lookup: maps iteration counts to 24-bit colour through a grey ramp or a programmable RAM.
// Two registered stages (2-cycle latency); a stalled output freezes both stages and drops in_ready.
module palette_lut #(
    parameter int          MAX_ITER     = 256,
    parameter logic [23:0] INSIDE_COLOR = 24'h000000,
    localparam int         IW           = $clog2(MAX_ITER)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_iter,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [23:0]   out_rgb,
    input  logic          mode,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          cycle_en,
    input  logic [IW-1:0] cycle_step,
    input  logic          frame_tick
);

    localparam int          GSH  = 8 - IW;
    localparam logic [IW-1:0] LAST = IW'(MAX_ITER - 1);

    logic          w_en;
    logic [IW-1:0] r_offset;

    logic          r_s1_vld;
    logic          r_s1_inside;
    logic          r_s1_mode;
    logic [IW-1:0] r_s1_idx;

    logic          r_out_vld;
    logic          r_s2_inside;
    logic          r_s2_mode;
    logic [IW-1:0] r_s2_idx;

    logic [23:0]   r_ram [MAX_ITER];
    logic [23:0]   r_ram_q;
    logic [7:0]    w_grey;
    logic [23:0]   w_rgb;

    assign w_en     = !r_out_vld || out_ready;
    assign in_ready = w_en;

    // A pixel captured on the same edge as the update still sees the old offset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_offset <= '0;
        end else if (frame_tick && cycle_en) begin
            r_offset <= r_offset + cycle_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld    <= 1'b0;
            r_s1_inside <= 1'b0;
            r_s1_mode   <= 1'b0;
            r_s1_idx    <= '0;
        end else if (w_en) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_idx    <= in_iter + r_offset;
                r_s1_inside <= (in_iter == LAST);
                r_s1_mode   <= mode;
            end
        end
    end

    // No reset on the array or its read register so they map onto block RAM; read-first on collisions.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_ram[wr_addr] <= wr_data;
        end
        if (w_en) begin
            r_ram_q <= r_ram[r_s1_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld   <= 1'b0;
            r_s2_inside <= 1'b0;
            r_s2_mode   <= 1'b0;
            r_s2_idx    <= '0;
        end else if (w_en) begin
            r_out_vld   <= r_s1_vld;
            r_s2_inside <= r_s1_inside;
            r_s2_mode   <= r_s1_mode;
            r_s2_idx    <= r_s1_idx;
        end
    end

    assign w_grey = 8'(r_s2_idx) << GSH;

    always_comb begin
        w_rgb = 24'h000000;
        if (r_out_vld) begin
            if (r_s2_inside) begin
                w_rgb = INSIDE_COLOR;
            end else if (r_s2_mode) begin
                w_rgb = r_ram_q;
            end else begin
                w_rgb = {w_grey, w_grey, w_grey};
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_rgb   = w_rgb;

endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut: stimulus pushes expected colours, a negedge monitor pops and compares.
module tb_palette_lut;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_iter;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_rgb;
    logic        mode;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic        cycle_en;
    logic [7:0]  cycle_step;
    logic        frame_tick;

    int          tests;
    int          fails;
    int          n_out;
    logic [23:0] exp_q[$];
    logic [23:0] mon_e;

    palette_lut #(.MAX_ITER(256), .INSIDE_COLOR(24'h000000)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_iter   (in_iter),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rgb   (out_rgb),
        .mode      (mode),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cycle_en  (cycle_en),
        .cycle_step(cycle_step),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    function automatic logic [23:0] grey(input logic [7:0] i);
        return {i, i, i};
    endfunction

    // Monitor: an output transfer happens when out_valid && out_ready at the coming edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %h expected none", out_rgb);
            end else begin
                mon_e = exp_q.pop_front();
                chk("scoreboard_rgb", {8'h00, out_rgb}, {8'h00, mon_e});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] it, input logic [23:0] e);
        int k;
        in_valid = 1'b1;
        in_iter  = it;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("send_accept", {31'd0, in_ready}, 32'd1);
        if (in_ready) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 40) begin
            cyc();
            k++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          saved;
        logic [23:0] held;
        logic [7:0]  p;

        tests = 0; fails = 0; n_out = 0;
        rst = 1'b1; in_valid = 1'b0; in_iter = 8'h00; out_ready = 1'b1; mode = 1'b0;
        wr_en = 1'b0; wr_addr = 8'h00; wr_data = 24'h0; cycle_en = 1'b0; cycle_step = 8'h00;
        frame_tick = 1'b0;
        repeat (3) cyc();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_rgb", {8'h00, out_rgb}, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        cyc();

        // Grey ramp with exact two-cycle latency.
        send(8'h40, 24'h404040);
        chk("lat_cycle1_vld", {31'd0, out_valid}, 32'd0);
        cyc();
        chk("lat_cycle2_vld", {31'd0, out_valid}, 32'd1);
        chk("lat_cycle2_rgb", {8'h00, out_rgb}, 32'h404040);
        drain();

        // Programmable palette and inside colour.
        wr(8'd5, 24'h0010A0);
        mode = 1'b1;
        send(8'd5, 24'h0010A0);
        send(8'd255, 24'h000000);
        drain();

        // Rotation: two ticks of +10, then a disabled tick, then a tick coinciding with a capture.
        mode = 1'b0; cycle_en = 1'b1; cycle_step = 8'd10;
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        send(8'd250, 24'h0E0E0E);
        cycle_en = 1'b0;
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        send(8'd1, 24'h151515);
        cycle_en = 1'b1; frame_tick = 1'b1;
        send(8'd3, 24'h171717);
        cycle_en = 1'b0;
        send(8'd3, 24'h212121);
        send(8'd255, 24'h000000);
        mode = 1'b1;
        send(8'd231, 24'h0010A0);
        mode = 1'b0;
        send(8'd10, 24'h282828);
        mode = 1'b1;
        send(8'd231, 24'h0010A0);
        drain();

        // Read-first collision on index 7 (offset 30, so in_iter 233 maps to 7).
        wr(8'd7, 24'h123456);
        mode = 1'b1; in_valid = 1'b1; in_iter = 8'd233;
        exp_q.push_back(24'h123456);
        cyc();
        wr_en = 1'b1; wr_addr = 8'd7; wr_data = 24'hABCDEF;
        exp_q.push_back(24'hABCDEF);
        cyc();
        wr_en = 1'b0; in_valid = 1'b0;
        drain();

        // Streaming with a three-cycle downstream stall.
        mode = 1'b0;
        n = 0;
        for (int t = 0; t < 14; t++) begin
            out_ready = !(t >= 4 && t < 7);
            p = 8'(n * 17 + 3);
            in_valid = (n < 8);
            in_iter  = p;
            @(negedge clk);
            if (t >= 4 && t < 7) begin
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                if (t == 4) held = out_rgb;
                else chk("stall_rgb_stable", {8'h00, out_rgb}, {8'h00, held});
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(grey(8'(p + 8'd30)));
                n++;
            end
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_accepted", n, 32'd8);
        drain();

        // Reset with two pixels in flight.
        in_valid = 1'b1; in_iter = 8'd1; cyc();
        in_iter = 8'd2; cyc();
        in_valid = 1'b0;
        saved = n_out;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_rgb", {8'h00, out_rgb}, 32'h0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) cyc();
        rst = 1'b0;
        repeat (6) cyc();
        chk("no_stale_output", n_out, saved);
        mode = 1'b0;
        send(8'h40, 24'h404040);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
